// File: rtl/rsa_modexp_core.sv
// RSA modular-exponentiation engine: C = M^E mod N, left-to-right square-and-multiply over a
// bit-serial Blakley multiplier. Define RSA_SKIP_LEADING_ZEROS_EN to skip exponent bits above the MSB 1 of E.
//
// state  | meaning
// IDLE   | ready=1, waiting for in_valid
// WAIT   | one-cycle gap while the registered FIFO output settles
// REDUCE | base = MM(1, M) = M mod N
// SQR    | R = MM(R, R) for exponent bit k
// MUL    | R = MM(R, base) when E[k] = 1
// DONE   | publish R on cipht, pulse valid, raise ready
module rsa_modexp_core #(
  parameter int W      = 32,
  parameter int RD_LAT = 1
) (
  input  logic         hclk,
  input  logic         hresetn,
  input  logic [W-1:0] plaint,
  input  logic         in_valid,
  output logic         ready,
  input  logic [W-1:0] exp_e,
  input  logic [W-1:0] mod_n,
  output logic         valid,
  output logic [W-1:0] cipht
);

  localparam int IW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_REDUCE, S_SQR, S_MUL, S_DONE} state_t;

  state_t        state_q;
  logic [W-1:0]  m_q, e_q, n_q, base_q, r_q, cipht_q;
  logic [W:0]    p_q, p_d;
  logic [IW-1:0] i_q, k_q, k_start;
  logic          ready_q, valid_q, e_zero;
  logic [W-1:0]  op_a, op_b;

  // One Blakley iteration; p < N on entry so the doubling never loses a bit.
  function automatic logic [W:0] mm_step(input logic [W:0] p, input logic [W-1:0] a,
                                         input logic [W-1:0] n, input logic b_bit);
    logic [W:0] t;
    t = {p[W-1:0], 1'b0};
    if (t >= {1'b0, n}) t = t - {1'b0, n};
    if (b_bit) begin
      t = t + {1'b0, a};
      if (t >= {1'b0, n}) t = t - {1'b0, n};
    end
    return t;
  endfunction

  always_comb begin
    op_a = r_q;
    op_b = r_q;
    case (state_q)
      S_REDUCE: begin op_a = W'(1); op_b = m_q; end
      S_MUL:    op_b = base_q;
      default:  ;
    endcase
    p_d = mm_step(p_q, op_a, n_q, op_b[i_q]);
  end

`ifdef RSA_SKIP_LEADING_ZEROS_EN
  always_comb begin
    k_start = '0;
    e_zero  = (e_q == '0);
    for (int j = 0; j < W; j++) begin
      if (e_q[j]) k_start = IW'(j);
    end
  end
`else
  always_comb begin
    k_start = IW'(W - 1);
    e_zero  = 1'b0;
  end
`endif

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      e_q     <= '0;
      n_q     <= '0;
      base_q  <= '0;
      r_q     <= '0;
      cipht_q <= '0;
      p_q     <= '0;
      i_q     <= '0;
      k_q     <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (in_valid && ready_q) begin
            ready_q <= 1'b0;
            e_q     <= exp_e;
            n_q     <= mod_n;
            p_q     <= '0;
            i_q     <= IW'(W - 1);
            if (RD_LAT == 0) begin
              m_q     <= plaint;
              state_q <= S_REDUCE;
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          m_q     <= plaint;
          state_q <= S_REDUCE;
        end
        S_REDUCE: begin
          if (n_q <= W'(1)) begin
            r_q     <= '0;
            state_q <= S_DONE;
          end else if (i_q != '0) begin
            p_q <= p_d;
            i_q <= i_q - 1'b1;
          end else begin
            base_q  <= p_d[W-1:0];
            r_q     <= W'(1);
            p_q     <= '0;
            i_q     <= IW'(W - 1);
            k_q     <= k_start;
            state_q <= e_zero ? S_DONE : S_SQR;
          end
        end
        S_SQR: begin
          if (i_q != '0) begin
            p_q <= p_d;
            i_q <= i_q - 1'b1;
          end else begin
            r_q <= p_d[W-1:0];
            p_q <= '0;
            i_q <= IW'(W - 1);
            if (e_q[k_q]) state_q <= S_MUL;
            else if (k_q == '0) state_q <= S_DONE;
            else k_q <= k_q - 1'b1;
          end
        end
        S_MUL: begin
          if (i_q != '0) begin
            p_q <= p_d;
            i_q <= i_q - 1'b1;
          end else begin
            r_q <= p_d[W-1:0];
            p_q <= '0;
            i_q <= IW'(W - 1);
            if (k_q == '0) begin
              state_q <= S_DONE;
            end else begin
              k_q     <= k_q - 1'b1;
              state_q <= S_SQR;
            end
          end
        end
        S_DONE: begin
          cipht_q <= r_q;
          valid_q <= 1'b1;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ready = ready_q;
  assign valid = valid_q;
  assign cipht = cipht_q;

endmodule

// File: tb/tb_rsa_modexp_core.sv
// Bench for rsa_modexp_core: directed vector table, random words against an arithmetic
// modexp model, and a reset-abort sequence.
module tb_rsa_modexp_core;
  localparam int W      = 32;
  localparam int RD_LAT = 1;

  logic         hclk = 1'b0;
  logic         hresetn;
  logic [W-1:0] plaint, exp_e, mod_n;
  logic         in_valid;
  logic         ready, valid;
  logic [W-1:0] cipht;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  rsa_modexp_core #(.W(W), .RD_LAT(RD_LAT)) dut (
    .hclk(hclk), .hresetn(hresetn), .plaint(plaint), .in_valid(in_valid), .ready(ready),
    .exp_e(exp_e), .mod_n(mod_n), .valid(valid), .cipht(cipht)
  );

  always #5 hclk = ~hclk;

  typedef struct {
    logic [W-1:0] m;
    logic [W-1:0] e;
    logic [W-1:0] n;
    logic [W-1:0] exp_c;
    bit           poke;
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic longint unsigned model_modexp(input longint unsigned m,
                                                   input longint unsigned e,
                                                   input longint unsigned n);
    longint unsigned r, b;
    if (n <= 1) return 0;
    r = 1;
    b = m % n;
    for (int k = W - 1; k >= 0; k--) begin
      r = (r * r) % n;
      if (e[k]) r = (r * b) % n;
    end
    return r;
  endfunction

  // Edges from the acceptance edge to the edge that raises valid.
  function automatic int model_lat(input logic [W-1:0] e, input logic [W-1:0] n);
    int pop, nb;
    if (n <= 1) return RD_LAT + 2;
    pop = $countones(e);
`ifdef RSA_SKIP_LEADING_ZEROS_EN
    nb = 0;
    for (int j = 0; j < W; j++) if (e[j]) nb = j + 1;
`else
    nb = W;
`endif
    return RD_LAT + 1 + W * (1 + nb + pop);
  endfunction

  // Called at a negedge; returns at a negedge one cycle after valid.
  task automatic run_word(input vec_t v, input string tag);
    int le, lat, vcnt, rdy_bad, rdy_at_v;
    logic [W-1:0] cap;
    bit got;
    le = model_lat(v.e, v.n);
    chk({tag, "_ready_before"}, longint'(ready), 1);
    plaint = v.m; exp_e = v.e; mod_n = v.n; in_valid = 1'b1;
    @(negedge hclk);
    in_valid = 1'b0;
    got = 0; lat = -1; vcnt = 0; rdy_bad = 0; rdy_at_v = 0; cap = '0;
    for (int c = 1; c <= le + 5; c++) begin
      @(negedge hclk);
      if (c == 50) begin
        plaint = $urandom; exp_e = $urandom; mod_n = $urandom;
      end
      if (v.poke && c == 100) in_valid = 1'b1;
      if (v.poke && c == 101) in_valid = 1'b0;
      if (valid) begin
        vcnt++;
        if (!got) begin
          got = 1; lat = c; cap = cipht; rdy_at_v = int'(ready);
        end
      end else if (!got && ready) begin
        rdy_bad++;
      end
      if (got && c > lat) break;
    end
    chk({tag, "_cipht"}, longint'(cap), longint'(v.exp_c));
    chk({tag, "_latency"}, lat, le);
    chk({tag, "_valid_pulses"}, vcnt, 1);
    chk({tag, "_ready_low_busy"}, rdy_bad, 0);
    chk({tag, "_ready_at_valid"}, rdy_at_v, 1);
  endtask

  vec_t vecs[$];
  vec_t rv;
  int   vbad;

  initial begin
    hresetn = 1'b0; in_valid = 1'b0; plaint = '0; exp_e = '0; mod_n = '0;
    repeat (2) @(negedge hclk);
    chk("rst_ready", longint'(ready), 1);
    chk("rst_valid", longint'(valid), 0);
    chk("rst_cipht", longint'(cipht), 0);
    hresetn = 1'b1;
    @(negedge hclk);

    vecs.push_back('{m: 65,   e: 17,   n: 3233, exp_c: 2790, poke: 0});
    vecs.push_back('{m: 2790, e: 2753, n: 3233, exp_c: 65,   poke: 1});
    vecs.push_back('{m: 3298, e: 17,   n: 3233, exp_c: 2790, poke: 0});
    vecs.push_back('{m: 77,   e: 17,   n: 1,    exp_c: 0,    poke: 0});
    vecs.push_back('{m: 5,    e: 9,    n: 0,    exp_c: 0,    poke: 0});
    vecs.push_back('{m: 123,  e: 0,    n: 3233, exp_c: 1,    poke: 0});
    vecs.push_back('{m: 0,    e: 5,    n: 3233, exp_c: 0,    poke: 0});
    vecs.push_back('{m: 65,   e: 17,   n: 3233, exp_c: 2790, poke: 0});
    vecs.push_back('{m: 2,    e: 17,   n: 3233, exp_c: 1752, poke: 0});
    foreach (vecs[i]) run_word(vecs[i], $sformatf("dir%0d", i));

    for (int i = 0; i < 6; i++) begin
      rv.n = (i == 0) ? 32'hFFFF_FFFB : $urandom_range(32'hFFFF_FFFF, 2);
      rv.m = $urandom;
      rv.e = (i == 1) ? 32'h0000_0003 : $urandom;
      rv.exp_c = W'(model_modexp(rv.m, rv.e, rv.n));
      rv.poke = 1;
      run_word(rv, $sformatf("rnd%0d", i));
    end

    // Reset in the middle of a word must abort it silently.
    plaint = 2; exp_e = 17; mod_n = 3233; in_valid = 1'b1;
    @(negedge hclk);
    in_valid = 1'b0;
    vbad = 0;
    repeat (300) begin
      @(negedge hclk);
      if (valid) vbad++;
    end
    chk("abort_busy_ready", longint'(ready), 0);
    hresetn = 1'b0;
    #1;
    chk("abort_ready", longint'(ready), 1);
    chk("abort_valid", longint'(valid), 0);
    chk("abort_cipht", longint'(cipht), 0);
    @(negedge hclk);
    hresetn = 1'b1;
    repeat (1200) begin
      @(negedge hclk);
      if (valid) vbad++;
    end
    chk("abort_no_valid", vbad, 0);
    chk("abort_ready_after", longint'(ready), 1);

    rv = '{m: 65, e: 17, n: 3233, exp_c: 2790, poke: 0};
    run_word(rv, "post_rst");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/rsa_modexp_core.md
Name: rsa_modexp_core

Overview:
- Modular-exponentiation engine that sits between the input word FIFO and the output word FIFO of the RSA AHB peripheral.
- Pops one W-bit plaintext word through a ready/in_valid handshake and computes C = M^E mod N by left-to-right square-and-multiply.
- Modular multiplication uses a bit-serial interleaved (Blakley) shift-add multiplier.
- Emits each result as a one-cycle valid pulse into the output FIFO write port.

Parameters:
- W, 32, operand width for plaintext, exponent, modulus and result.
- RD_LAT, 1, cycles between in_valid and plaint becoming valid. Legal values: 0 or 1; 1 matches a registered-output FIFO.

Ports:
- hclk  in  1  clock.
- hresetn  in  1  reset.
- plaint  in  W  plaintext word from the input FIFO Q.
- in_valid  in  1  input FIFO read strobe; only meaningful while ready=1.
- ready  out  1  engine idle and able to accept a word.
- exp_e  in  W  exponent E; quasi-static.
- mod_n  in  W  modulus N; quasi-static.
- valid  out  1  one-cycle result strobe, wired to the output FIFO WrEn.
- cipht  out  W  result word; held until the next result.

Behaviour:
- Reset is hresetn, asynchronous, active-low; clock is hclk.
- Reset values: state=IDLE, ready=1, valid=0, cipht=0, all internal registers 0.
- Reset asserted mid-operation aborts immediately; no valid is produced for the aborted word.
- Handshake:
  - A word is accepted on a rising edge where in_valid=1 and ready=1.
  - ready is registered and falls in the cycle after acceptance.
  - in_valid while ready=0 is ignored.
  - exp_e and mod_n are sampled at acceptance; later changes do not affect the word in flight.
  - There is no output backpressure: valid is asserted regardless of downstream FIFO state.
- Data capture: with RD_LAT=0, plaint is captured on the acceptance edge; with RD_LAT=1, it is captured one edge later (state WAIT).
- States: IDLE -> (WAIT) -> REDUCE -> SQR -> MUL -> ... -> DONE -> IDLE.
- Modular multiplier MM(a,b), with a<N:
  - Performs W iterations, i=W-1..0, one per cycle.
  - Step 1: P=2P; if P>=N then P-=N.
  - Step 2: if b[i]=1, P+=a; if P>=N then P-=N.
  - Datapath is W+1 bits wide. P is cleared at the start of each MM. Each MM takes exactly W cycles, with no inter-multiply overhead cycles.
- REDUCE computes base = MM(1, M) = M mod N, so any M is legal, including M>=N.
- Exponent loop:
  - R is initialised to 1 mod N.
  - For each exponent bit k=W-1..0: SQR computes R=MM(R,R); if E[k]=1, MUL computes R=MM(R,base).
- DONE: cipht<=R, valid=1 for one cycle, ready=1 in that same cycle, state -> IDLE.
- Latency from the capture edge to valid = 1 + W*(1 + nbits + popcount(E)) cycles.
  - nbits = W.
  - Increase the latency by 1 if RD_LAT=1.
- Degenerate cases:
  - N=0 or N=1: skip all multiplies; cipht=0 with valid two cycles after capture.
  - E=0: result is 1 (for N>1).
  - M=0 with E>0: result is 0.

Optional Feature:
- Macro: RSA_SKIP_LEADING_ZEROS_EN.
- When defined:
  - Exponent bits above the most significant 1 of E are skipped, i.e. nbits = index of the MSB 1 plus 1.
  - A priority encoder on the sampled E determines the start index; this adds no extra cycle.
  - With E=0, no SQR/MUL cycles run and the result is 1 after the REDUCE stage.
- When undefined: always iterate all W bits.
- Results are identical in both builds; only latency differs.

Test Plan:
- W=32, RD_LAT=1, N=3233, E=17, M=65 -> valid once with cipht=2790; latency = 1+1+32*(1+32+2) = 1122 cycles (no macro); ready=0 throughout the computation.
- Same N, E=2753, M=2790 -> cipht=65; in_valid pulsed mid-computation is ignored, and exactly one valid is produced.
- N=3233, E=17, M=3298 (M>=N) -> cipht=2790, proving the REDUCE stage.
- N=1 with any M -> cipht=0; N=3233, E=0, M=123 -> cipht=1; N=3233, E=5, M=0 -> cipht=0.
- Back-to-back: two words with M=65 then M=2 (E=17, N=3233) -> 2790 then 2^17 mod 3233 = 1752, each valid a single cycle and in order; hresetn pulsed mid-second-word -> no valid, ready=1, cipht=0.
- Build with RSA_SKIP_LEADING_ZEROS_EN, E=17, M=65, N=3233 -> cipht=2790; latency = 1+1+32*(1+5+2) = 258 cycles.
